pwm_precondition_scheduler: RTL and testbench

//  Sequences the shared PWM preconditioner engine (one engine serves all DEPTH transducers).

---
 rtl/pwm_precondition_scheduler_if.sv | 27 ++
 rtl/pwm_precondition_scheduler.sv | 142 ++++++++++++++
 tb/tb_pwm_precondition_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_precondition_scheduler_if.sv
// Request/grant and control bundle between the PWM preconditioner scheduler and its surroundings.
// master drives the update requests and period tick; slave is the scheduler itself.
interface pwm_precondition_scheduler_if #(
    parameter int DROP_WIDTH = 8
);
    logic                  update_tick;
    logic                  req_normal;
    logic                  req_stm;
    logic                  stm_mode;
    logic                  src_sel;
    logic                  start;
    logic                  latch;
    logic                  busy;
    logic                  ack_normal;
    logic                  ack_stm;
    logic [DROP_WIDTH-1:0] drop_cnt;

    modport master (
        output update_tick, req_normal, req_stm, stm_mode,
        input  src_sel, start, latch, busy, ack_normal, ack_stm, drop_cnt
    );

    modport slave (
        input  update_tick, req_normal, req_stm, stm_mode,
        output src_sel, start, latch, busy, ack_normal, ack_stm, drop_cnt
    );
endinterface

// File: rtl/pwm_precondition_scheduler.sv
// Arbitrates NORMAL/STM updates onto the shared preconditioner engine, pulses START, then
// pulses LATCH on the first period tick after the engine run time has elapsed.
//
// state     | meaning
// IDLE      | no run in progress; grant a pending request (STM before NORMAL)
// SETUP     | source selected; pulse START and load the run timer
// RUN       | engine output unstable; timer counts down, ticks ignored
// WAIT_TICK | engine output stable; LATCH on the next period tick
module pwm_precondition_scheduler #(
    parameter int DEPTH      = 249,
    parameter int RUN_CYCLES = 260,
    parameter int DROP_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pwm_precondition_scheduler_if.slave   bus
);
    // The engine needs at least DEPTH+9 cycles; a smaller RUN_CYCLES is raised to that floor.
    localparam int RUN_LEN = (RUN_CYCLES < DEPTH + 9) ? DEPTH + 9 : RUN_CYCLES;
    localparam int CNT_W   = $clog2(RUN_LEN);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETUP     = 2'd1,
        RUN       = 2'd2,
        WAIT_TICK = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pend_n_q, pend_n_d;
    logic                  pend_s_q, pend_s_d;
    logic                  src_sel_q, src_sel_d;
    logic                  start_q, start_d;
    logic                  latch_q, latch_d;
    logic                  busy_q, busy_d;
    logic                  ack_n_q, ack_n_d;
    logic                  ack_s_q, ack_s_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic                  grant_n, grant_s;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_sel_d = src_sel_q;
        start_d   = 1'b0;
        latch_d   = 1'b0;
        ack_n_d   = 1'b0;
        ack_s_d   = 1'b0;
        grant_n   = 1'b0;
        grant_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_s_q && bus.stm_mode) begin
                    grant_s   = 1'b1;
                    src_sel_d = 1'b1;
                    ack_s_d   = 1'b1;
                    state_d   = SETUP;
                end else if (pend_n_q) begin
                    grant_n   = 1'b1;
                    src_sel_d = 1'b0;
                    ack_n_d   = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                start_d = 1'b1;
                cnt_d   = CNT_W'(RUN_LEN - 1);
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_TICK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_TICK: begin
                if (bus.update_tick) begin
                    latch_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        // A request on the grant edge re-arms its flag so it is served on the next run.
        pend_n_d = bus.req_normal ? 1'b1 : (grant_n ? 1'b0 : pend_n_q);

        drop_d   = drop_q;
        pend_s_d = pend_s_q;
        if (!bus.stm_mode) begin
            pend_s_d = 1'b0;
        end else if (bus.req_stm) begin
            pend_s_d = 1'b1;
            if (pend_s_q && !grant_s && (drop_q != '1)) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (grant_s) begin
            pend_s_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_n_q  <= 1'b0;
            pend_s_q  <= 1'b0;
            src_sel_q <= 1'b0;
            start_q   <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            ack_n_q   <= 1'b0;
            ack_s_q   <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_n_q  <= pend_n_d;
            pend_s_q  <= pend_s_d;
            src_sel_q <= src_sel_d;
            start_q   <= start_d;
            latch_q   <= latch_d;
            busy_q    <= busy_d;
            ack_n_q   <= ack_n_d;
            ack_s_q   <= ack_s_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.src_sel    = src_sel_q;
    assign bus.start      = start_q;
    assign bus.latch      = latch_q;
    assign bus.busy       = busy_q;
    assign bus.ack_normal = ack_n_q;
    assign bus.ack_stm    = ack_s_q;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_pwm_precondition_scheduler.sv
// Bench for pwm_precondition_scheduler: directed scenarios plus random traffic against a
// timestamp-based reference model of grant, START, run window and LATCH timing.
module tb_pwm_precondition_scheduler;
    localparam int RUN  = 260;
    localparam int DW   = 8;
    localparam int DMAX = (1 << DW) - 1;

    logic clk;
    logic rst_n;

    pwm_precondition_scheduler_if #(.DROP_WIDTH(DW)) bus ();

    pwm_precondition_scheduler #(
        .DEPTH      (249),
        .RUN_CYCLES (RUN),
        .DROP_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    // Reference model: a run is described only by its grant edge index g.
    longint m_n;
    longint m_g;
    bit     m_active;
    bit     m_pn, m_ps, m_src;
    int     m_drop;
    bit     e_start, e_latch, e_an, e_as;

    int tick_mode;
    int tick_per;
    int cyc_cnt;
    int obs_ack_s;
    int obs_ack_n;
    int obs_start;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_g = 0; m_active = 0;
        m_pn = 0; m_ps = 0; m_src = 0; m_drop = 0;
    endtask

    task automatic model_step(input bit rn, input bit rs, input bit mode, input bit tk);
        bit gs, gn;
        gs = 0; gn = 0;
        e_start = m_active && (m_n == m_g + 1);
        e_latch = 0; e_an = 0; e_as = 0;
        if (m_active) begin
            if ((m_n > m_g + 1 + RUN) && tk) begin
                e_latch  = 1;
                m_active = 0;
            end
        end else begin
            if (m_ps && mode) gs = 1;
            else if (m_pn)    gn = 1;
            if (gs || gn) begin
                m_active = 1;
                m_g      = m_n;
                m_src    = gs;
                e_as     = gs;
                e_an     = gn;
            end
        end
        if (!mode) begin
            m_ps = 0;
        end else if (rs) begin
            if (m_ps && !gs && m_drop < DMAX) m_drop++;
            m_ps = 1;
        end else if (gs) begin
            m_ps = 0;
        end
        if (rn) m_pn = 1;
        else if (gn) m_pn = 0;
        m_n++;
    endtask

    task automatic compare_all();
        check_eq("start",      bus.start,      e_start);
        check_eq("latch",      bus.latch,      e_latch);
        check_eq("ack_normal", bus.ack_normal, e_an);
        check_eq("ack_stm",    bus.ack_stm,    e_as);
        check_eq("src_sel",    bus.src_sel,    m_src);
        check_eq("busy",       bus.busy,       m_active);
        check_eq("drop_cnt",   32'(bus.drop_cnt), 32'(m_drop));
        obs_ack_s += int'(bus.ack_stm);
        obs_ack_n += int'(bus.ack_normal);
        obs_start += int'(bus.start);
    endtask

    task automatic drive(input bit rn, input bit rs, input bit tk_force);
        bit tk;
        @(negedge clk);
        tk = tk_force;
        if (tick_mode == 1 && (cyc_cnt % tick_per) == 0) tk = 1;
        if (tick_mode == 2 && $urandom_range(0, 39) == 0) tk = 1;
        bus.req_normal  = rn;
        bus.req_stm     = rs;
        bus.update_tick = tk;
        cyc_cnt++;
        @(posedge clk);
        #1;
        model_step(rn, rs, bus.stm_mode, tk);
        compare_all();
    endtask

    task automatic idle(input int k);
        repeat (k) drive(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_normal = 0; bus.req_stm = 0; bus.update_tick = 0;
        #1;
        check_eq("rst_start",   bus.start,      0);
        check_eq("rst_latch",   bus.latch,      0);
        check_eq("rst_busy",    bus.busy,       0);
        check_eq("rst_ack_n",   bus.ack_normal, 0);
        check_eq("rst_ack_s",   bus.ack_stm,    0);
        check_eq("rst_src_sel", bus.src_sel,    0);
        check_eq("rst_drop",    32'(bus.drop_cnt), 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((bus.busy || bus.ack_normal || bus.ack_stm) && k < budget) begin
            drive(0, 0, ($urandom_range(0, 19) == 0));
            k++;
        end
        check_eq("drain_timeout", 32'(k < budget), 1);
        idle(3);
    endtask

    initial begin
        int s;
        tests_run = 0; tests_failed = 0;
        tick_mode = 0; tick_per = 100; cyc_cnt = 0;
        obs_ack_s = 0; obs_ack_n = 0; obs_start = 0;
        rst_n = 1'b0;
        bus.req_normal = 0; bus.req_stm = 0; bus.update_tick = 0; bus.stm_mode = 0;
        model_reset();
        do_reset();

        // NORMAL request, early tick ignored, later tick latches
        drive(1, 0, 0);
        repeat (249) drive(0, 0, 0);
        drive(0, 0, 1);
        repeat (49) drive(0, 0, 0);
        drive(0, 0, 1);
        idle(5);

        // Tick on the last RUN edge is ignored, the next one latches
        drive(1, 0, 0);
        repeat (261) drive(0, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 1);
        idle(5);

        // Simultaneous requests: STM first, NORMAL right after its LATCH
        bus.stm_mode = 1;
        obs_ack_s = 0; obs_ack_n = 0;
        drive(1, 1, 0);
        idle(270);
        drive(0, 0, 1);
        idle(270);
        drive(0, 0, 1);
        idle(5);
        check_eq("tie_ack_stm",    32'(obs_ack_s), 1);
        check_eq("tie_ack_normal", 32'(obs_ack_n), 1);

        // Periodic ticks during RUN
        tick_mode = 1; tick_per = 100; cyc_cnt = 1;
        obs_start = 0;
        drive(1, 0, 0);
        idle(400);
        tick_mode = 0;
        idle(5);
        check_eq("periodic_one_start", 32'(obs_start), 1);

        // STM disabled: requests discarded
        bus.stm_mode = 0;
        obs_ack_s = 0; obs_start = 0;
        drive(0, 1, 0); idle(2); drive(0, 1, 0); drive(0, 1, 0);
        idle(10);
        check_eq("stm_off_ack",   32'(obs_ack_s), 0);
        check_eq("stm_off_start", 32'(obs_start), 0);

        // STM flood while busy saturates the drop counter
        bus.stm_mode = 1;
        obs_ack_s = 0;
        drive(0, 1, 0);
        repeat (300) drive(0, 1, 0);
        idle(5);
        drive(0, 0, 1);
        idle(270);
        drive(0, 0, 1);
        idle(5);
        check_eq("drop_sat",      32'(bus.drop_cnt), DMAX);
        check_eq("flood_ack_stm", 32'(obs_ack_s), 2);

        // Reset mid-run aborts; normal operation afterwards
        drive(1, 0, 0);
        idle(52);
        do_reset();
        obs_ack_n = 0;
        idle(20);
        drive(1, 0, 0);
        repeat (299) drive(0, 0, 0);
        drive(0, 0, 1);
        idle(5);
        check_eq("post_rst_ack_n", 32'(obs_ack_n), 1);

        // Random traffic
        tick_mode = 2;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 299) == 0) bus.stm_mode = ~bus.stm_mode;
            s = $urandom_range(0, 999);
            drive((s < 15), ($urandom_range(0, 24) == 0), 0);
        end
        tick_mode = 0;
        drain(3000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
